// File: rtl/sudoku_pkg.sv
// Shared constants for the sudoku game RAM: row-word field layout, owner tags
// and arbiter FSM encoding.
package sudoku_pkg;
  localparam int PROT_LSB  = 20;
  localparam int BLANK_LSB = 16;
  localparam int DIGIT_W   = 4;
  localparam int NCOL      = 4;
  localparam int ROWS      = 4;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_E    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_C    = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_WRITE   = 2'd3;
endpackage

// File: rtl/sudoku_cell_update.sv
// Combinational single-cell edit of a row word: replaces one digit and its blank
// flag, and reports whether the cell is write-protected or the digit is invalid.
module sudoku_cell_update #(
  parameter int DATA_W = 24,
  parameter int NCOL   = 4
) (
  input  logic [DATA_W-1:0]       i_word,
  input  logic [$clog2(NCOL)-1:0] i_col,
  input  logic [3:0]              i_digit,
  input  logic                    i_clear,
  output logic [DATA_W-1:0]       o_word,
  output logic                    o_prot,
  output logic                    o_inval
);
  import sudoku_pkg::*;
  localparam int COL_W = $clog2(NCOL);

  // Constant-index loop keeps every select static instead of a computed part-select.
  always_comb begin
    o_word  = i_word;
    o_prot  = 1'b0;
    o_inval = !i_clear && (i_digit == 4'd0);
    for (int c = 0; c < NCOL; c++) begin
      if (i_col == COL_W'(c)) begin
        o_word[DIGIT_W*c +: DIGIT_W] = i_clear ? 4'd0 : i_digit;
        o_word[BLANK_LSB+c]          = i_clear;
        o_prot                       = i_word[PROT_LSB+c];
      end
    end
  end
endmodule

// File: rtl/sudoku_ram_arbiter.sv
// Owner of the single-port game RAM: arbitrates editor / display / checker,
// performs protected read-modify-write edits and fair display/checker sharing.
module sudoku_ram_arbiter #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 24,
  parameter int NCOL         = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  output logic [ADDR_W-1:0]       o_ram_addr,
  output logic                    o_ram_we,
  output logic [DATA_W-1:0]       o_ram_din,
  input  logic [DATA_W-1:0]       i_ram_dout,
  input  logic                    i_e_req,
  input  logic [ADDR_W-1:0]       i_e_row,
  input  logic [$clog2(NCOL)-1:0] i_e_col,
  input  logic [3:0]              i_e_digit,
  input  logic                    i_e_clear,
  output logic                    o_e_ack,
  output logic                    o_e_rej,
  input  logic                    i_d_req,
  input  logic [ADDR_W-1:0]       i_d_addr,
  output logic                    o_d_valid,
  output logic [DATA_W-1:0]       o_d_data,
  input  logic [ADDR_W-1:0]       i_c_addr,
  output logic                    o_c_valid,
  output logic [DATA_W-1:0]       o_c_data
);
  import sudoku_pkg::*;
  localparam int COL_W = $clog2(NCOL);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [1:0]        r_state, r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_din;
  logic [COL_W-1:0]  r_e_col;
  logic [3:0]        r_e_digit;
  logic              r_e_clear;
  logic [CNT_W-1:0]  r_starve;

  logic [DATA_W-1:0] w_new_word;
  logic              w_prot, w_inval, w_cap, w_e_refuse;

  sudoku_cell_update #(.DATA_W(DATA_W), .NCOL(NCOL)) u_cell (
    .i_word  (i_ram_dout),
    .i_col   (r_e_col),
    .i_digit (r_e_digit),
    .i_clear (r_e_clear),
    .o_word  (w_new_word),
    .o_prot  (w_prot),
    .o_inval (w_inval)
  );

  assign w_cap      = (r_state == ST_CAPTURE);
  assign w_e_refuse = w_cap && (r_owner == OWN_E) && (w_prot || w_inval);

  // Pulses decode from state so an async reset clears them in the same instant.
  assign o_d_valid  = w_cap && (r_owner == OWN_D);
  assign o_c_valid  = w_cap && (r_owner == OWN_C);
  assign o_e_rej    = w_e_refuse;
  assign o_e_ack    = w_e_refuse || (r_state == ST_WRITE);
  assign o_d_data   = i_ram_dout;
  assign o_c_data   = i_ram_dout;
  assign o_ram_addr = r_addr;
  assign o_ram_we   = r_we;
  assign o_ram_din  = r_din;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_NONE;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_din     <= '0;
      r_e_col   <= '0;
      r_e_digit <= '0;
      r_e_clear <= 1'b0;
      r_starve  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ISSUE;
          if (i_e_req) begin
            r_owner   <= OWN_E;
            r_addr    <= i_e_row;
            r_e_col   <= i_e_col;
            r_e_digit <= i_e_digit;
            r_e_clear <= i_e_clear;
          end else if (i_d_req && (r_starve != STARVE_MAX)) begin
            r_owner  <= OWN_D;
            r_addr   <= i_d_addr;
            r_starve <= r_starve + 1'b1;
          end else begin
            r_owner  <= OWN_C;
            r_addr   <= i_c_addr;
            r_starve <= '0;
          end
        end
        ST_ISSUE: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          if ((r_owner == OWN_E) && !(w_prot || w_inval)) begin
            r_din   <= w_new_word;
            r_we    <= 1'b1;
            r_state <= ST_WRITE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sudoku_ram_arbiter.sv
// Bench for sudoku_ram_arbiter: directed scenarios plus a randomized mixed-traffic
// run checked against a row-array reference model.
module tb_sudoku_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ram_addr;
  logic        ram_we;
  logic [23:0] ram_din, ram_dout;
  logic        e_req, e_clear, e_ack, e_rej;
  logic [1:0]  e_row, e_col;
  logic [3:0]  e_digit;
  logic        d_req, d_valid;
  logic [1:0]  d_addr, c_addr;
  logic [23:0] d_data, c_data;
  logic        c_valid;

  logic [23:0] mem [4];
  logic [23:0] ref_mem [4];
  logic        bd_we;
  logic [1:0]  bd_addr;
  logic [23:0] bd_data;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sudoku_ram_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_din(ram_din), .i_ram_dout(ram_dout),
    .i_e_req(e_req), .i_e_row(e_row), .i_e_col(e_col), .i_e_digit(e_digit), .i_e_clear(e_clear),
    .o_e_ack(e_ack), .o_e_rej(e_rej),
    .i_d_req(d_req), .i_d_addr(d_addr), .o_d_valid(d_valid), .o_d_data(d_data),
    .i_c_addr(c_addr), .o_c_valid(c_valid), .o_c_data(c_data)
  );

  // Synchronous single-port RAM, read-first, with a bench backdoor for preloading.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic logic [23:0] model_edit(input logic [23:0] old, input logic [1:0] col,
                                             input logic [3:0] dig, input logic clr);
    int sh = 4 * int'(col);
    int bb = 16 + int'(col);
    logic [23:0] w = old & ~(24'hF << sh) & ~(24'h1 << bb);
    return w | (24'(clr ? 4'd0 : dig) << sh) | (24'(clr) << bb);
  endfunction

  function automatic logic model_rej(input logic [23:0] old, input logic [1:0] col,
                                     input logic [3:0] dig, input logic clr);
    return (((old >> (20 + int'(col))) & 24'h1) != 0) || (!clr && dig == 4'd0);
  endfunction

  task automatic load_row(input logic [1:0] a, input logic [23:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1 bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; e_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one edit from a just-released reset and reports what the DUT did.
  task automatic run_edit(input logic [1:0] row, input logic [1:0] col, input logic [3:0] dig,
                          input logic clr, input int drop_at, output int ack_n, output logic rej,
                          output int we_cnt, output logic [23:0] we_din, output logic [1:0] we_addr);
    e_row = row; e_col = col; e_digit = dig; e_clear = clr; e_req = 1'b1;
    ack_n = -1; rej = 1'b0; we_cnt = 0; we_din = '0; we_addr = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ram_we) begin we_cnt++; we_din = ram_din; we_addr = ram_addr; end
      if (e_ack && ack_n < 0) begin ack_n = k; rej = e_rej; e_req = 1'b0; end
      if (k == drop_at) e_req = 1'b0;
    end
    e_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0; #1;
    nvec++; if ({ram_addr, ram_we, ram_din} !== 27'd0) begin nerr++;
      $display("FAIL reset_ram: addr=%h we=%b din=%h, want all 0", ram_addr, ram_we, ram_din); end
    nvec++; if ({e_ack, e_rej, d_valid, c_valid} !== 4'b0) begin nerr++;
      $display("FAIL reset_pulses: %b, want 0000", {e_ack, e_rej, d_valid, c_valid}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int seen = 0;
    load_row(2'd2, 24'h0A1234);
    do_reset();
    c_addr = 2'd2;
    e_row = 2'd2; e_col = 2'd1; e_digit = 4'd7; e_clear = 1'b0; e_req = 1'b1;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      @(negedge clk);
      if (ram_we) seen = 1;
    end
    nvec++; if (seen == 0) begin nerr++; $display("FAIL midwrite_we_seen: got 0, want 1"); end
    rst_n = 1'b0; e_req = 1'b0; #1;
    nvec++; if (ram_we !== 1'b0 || e_ack !== 1'b0) begin nerr++;
      $display("FAIL midwrite_async_drop: we=%b ack=%b, want 0 0", ram_we, e_ack); end
    @(posedge clk); #1;
    nvec++; if (mem[2] !== 24'h0A1234) begin nerr++;
      $display("FAIL midwrite_row2: got %h want 0a1234", mem[2]); end
    @(negedge clk); rst_n = 1'b1;
    nvec++; if ({ram_we, e_ack, e_rej, d_valid, c_valid} !== 5'b0) begin nerr++;
      $display("FAIL midwrite_release: %b want 00000", {ram_we, e_ack, e_rej, d_valid, c_valid}); end
    repeat (2) @(negedge clk);
    nvec++; if (c_valid !== 1'b1 || c_data !== 24'h0A1234) begin nerr++;
      $display("FAIL midwrite_idle_restart: c_valid=%b data=%h want 1 0a1234", c_valid, c_data); end
  endtask

  task automatic test_edit_accept();
    int ack_n, we_cnt; logic rej; logic [23:0] din; logic [1:0] wa;
    load_row(2'd1, 24'h0F0000);
    do_reset();
    run_edit(2'd1, 2'd2, 4'd3, 1'b0, 0, ack_n, rej, we_cnt, din, wa);
    nvec++; if (ack_n != 3 || rej !== 1'b0) begin nerr++;
      $display("FAIL accept_ack: cycle=%0d rej=%b want 3 0", ack_n, rej); end
    nvec++; if (we_cnt != 1 || din !== 24'h0B0300 || wa !== 2'd1) begin nerr++;
      $display("FAIL accept_write: n=%0d din=%h addr=%0d want 1 0b0300 1", we_cnt, din, wa); end
    nvec++; if (mem[1] !== 24'h0B0300) begin nerr++;
      $display("FAIL accept_ram: got %h want 0b0300", mem[1]); end
    ref_mem[1] = 24'h0B0300;
  endtask

  task automatic test_protect();
    int ack_n, we_cnt; logic rej; logic [23:0] din; logic [1:0] wa;
    load_row(2'd0, 24'h400200);
    do_reset();
    run_edit(2'd0, 2'd2, 4'd1, 1'b0, 1, ack_n, rej, we_cnt, din, wa);
    nvec++; if (ack_n != 2 || rej !== 1'b1) begin nerr++;
      $display("FAIL protect_ack: cycle=%0d rej=%b want 2 1", ack_n, rej); end
    nvec++; if (we_cnt != 0 || mem[0] !== 24'h400200) begin nerr++;
      $display("FAIL protect_nowrite: writes=%0d row=%h want 0 400200", we_cnt, mem[0]); end
  endtask

  task automatic test_invalid_clear();
    int ack_n, we_cnt; logic rej; logic [23:0] din; logic [1:0] wa;
    load_row(2'd3, 24'h000057);
    do_reset();
    run_edit(2'd3, 2'd1, 4'd0, 1'b0, 0, ack_n, rej, we_cnt, din, wa);
    nvec++; if (ack_n != 2 || rej !== 1'b1 || we_cnt != 0) begin nerr++;
      $display("FAIL invalid_digit: cycle=%0d rej=%b writes=%0d want 2 1 0", ack_n, rej, we_cnt); end
    do_reset();
    run_edit(2'd3, 2'd0, 4'd9, 1'b1, 0, ack_n, rej, we_cnt, din, wa);
    nvec++; if (ack_n != 3 || rej !== 1'b0) begin nerr++;
      $display("FAIL clear_ack: cycle=%0d rej=%b want 3 0", ack_n, rej); end
    nvec++; if (we_cnt != 1 || din !== 24'h010050) begin nerr++;
      $display("FAIL clear_word: writes=%0d din=%h want 1 010050", we_cnt, din); end
    ref_mem[3] = 24'h010050;
  endtask

  task automatic test_starvation();
    int npulse = 0, last = -1, cnt = 0;
    byte exp_g, got_g;
    for (int r = 0; r < 4; r++) load_row(2'(r), 24'($urandom));
    do_reset();
    c_addr = 2'd0; d_addr = 2'($urandom); d_req = 1'b1;
    for (int k = 1; k <= 40 && npulse < 10; k++) begin
      @(negedge clk);
      if (d_valid || c_valid) begin
        if (cnt == 4) begin exp_g = "C"; cnt = 0; end else begin exp_g = "D"; cnt++; end
        got_g = d_valid ? "D" : "C";
        nvec++; if (got_g != exp_g || (d_valid && c_valid)) begin nerr++;
          $display("FAIL starve_grant%0d: got %c want %c", npulse, got_g, exp_g); end
        nvec++; if ((last < 0 && k != 2) || (last >= 0 && k - last != 3)) begin nerr++;
          $display("FAIL starve_spacing%0d: cycle %0d prev %0d", npulse, k, last); end
        if (d_valid) begin
          nvec++; if (d_data !== ref_mem[d_addr]) begin nerr++;
            $display("FAIL starve_ddata: got %h want %h", d_data, ref_mem[d_addr]); end
          d_addr = 2'($urandom);
        end else begin
          nvec++; if (c_data !== ref_mem[c_addr]) begin nerr++;
            $display("FAIL starve_cdata row%0d: got %h want %h", c_addr, c_data, ref_mem[c_addr]); end
          c_addr = c_addr + 2'd1;
        end
        last = k; npulse++;
      end
    end
    nvec++; if (npulse != 10) begin nerr++; $display("FAIL starve_timeout: got %0d pulses want 10", npulse); end
    d_req = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [23:0] w = 24'($urandom) & 24'h0FFFFF;
    int ack_k = -1, dv_k = -1;
    logic rej = 1'b0; logic [23:0] dd = '0;
    load_row(2'd2, w);
    do_reset();
    e_row = 2'd2; e_col = 2'($urandom); e_digit = 4'($urandom_range(1, 9)); e_clear = 1'b0;
    d_addr = 2'd2; e_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (e_ack && ack_k < 0) begin ack_k = k; rej = e_rej; e_req = 1'b0; end
      if (d_valid && dv_k < 0) begin dv_k = k; dd = d_data; d_req = 1'b0; end
    end
    nvec++; if (ack_k != 3 || rej !== 1'b0) begin nerr++;
      $display("FAIL same_cycle_edit: ack=%0d rej=%b want 3 0", ack_k, rej); end
    nvec++; if (dv_k != 6) begin nerr++; $display("FAIL same_cycle_dvalid: cycle %0d want 6", dv_k); end
    nvec++; if (dd !== model_edit(w, e_col, e_digit, 1'b0)) begin nerr++;
      $display("FAIL same_cycle_ddata: got %h want %h", dd, model_edit(w, e_col, e_digit, 1'b0)); end
    ref_mem[2] = model_edit(w, e_col, e_digit, 1'b0);
  endtask

  task automatic test_back_to_back();
    int e_wait = 0;
    logic xr;
    for (int r = 0; r < 4; r++) load_row(2'(r), 24'($urandom));
    do_reset();
    c_addr = 2'($urandom);
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      nvec++; if (int'(e_ack) + int'(d_valid) + int'(c_valid) > 1) begin nerr++;
        $display("FAIL rand_exclusive@%0d: ack=%b dv=%b cv=%b", k, e_ack, d_valid, c_valid); end
      if (ram_we && !e_ack) begin nvec++; nerr++; $display("FAIL rand_write_noack@%0d", k); end
      if (e_ack) begin
        xr = model_rej(ref_mem[e_row], e_col, e_digit, e_clear);
        nvec++; if (e_rej !== xr || ram_we !== !xr) begin nerr++;
          $display("FAIL rand_edit@%0d: rej=%b we=%b want rej %b", k, e_rej, ram_we, xr); end
        if (!xr) begin
          nvec++; if (ram_din !== model_edit(ref_mem[e_row], e_col, e_digit, e_clear) || ram_addr !== e_row) begin
            nerr++; $display("FAIL rand_din@%0d: got %h@%0d want %h@%0d", k, ram_din, ram_addr,
                             model_edit(ref_mem[e_row], e_col, e_digit, e_clear), e_row); end
          ref_mem[e_row] = model_edit(ref_mem[e_row], e_col, e_digit, e_clear);
        end
        e_req = 1'b0; e_wait = 0;
      end
      if (d_valid) begin
        nvec++; if (d_data !== ref_mem[d_addr]) begin nerr++;
          $display("FAIL rand_ddata@%0d: got %h want %h", k, d_data, ref_mem[d_addr]); end
        d_req = 1'b0;
      end
      if (c_valid) begin
        nvec++; if (c_data !== ref_mem[c_addr]) begin nerr++;
          $display("FAIL rand_cdata@%0d: got %h want %h", k, c_data, ref_mem[c_addr]); end
        c_addr = 2'($urandom);
      end
      if (e_req) begin
        e_wait++;
        if (e_wait > 12) begin nvec++; nerr++; e_req = 1'b0; e_wait = 0;
          $display("FAIL rand_editor_starved@%0d: waited >12 cycles, want ack", k); end
      end else if ($urandom_range(0, 3) == 0) begin
        e_row = 2'($urandom); e_col = 2'($urandom); e_digit = 4'($urandom_range(0, 9));
        e_clear = ($urandom_range(0, 4) == 0); e_req = 1'b1;
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin d_addr = 2'($urandom); d_req = 1'b1; end
    end
    e_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    e_req = 1'b0; e_row = '0; e_col = '0; e_digit = '0; e_clear = 1'b0;
    d_req = 1'b0; d_addr = '0; c_addr = '0;
    test_reset();
    test_reset_mid_write();
    test_edit_accept();
    test_protect();
    test_invalid_clear();
    test_starvation();
    test_same_cycle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
